alu_share_arbiter: RTL

- Round-robin arbiter and sequencer that shares one WIDTH-bit ALU datapath between two requesters.
- Drives the 2:1 operand-mux select and latches the selected operands.
- Runs one ALU operation per grant and holds the result until the winning requester acknowledges it.
- Sits between the requester logic and the structural mux/ALU datapath.

---
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter/sequencer sharing one ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  input  logic             ack,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             result_id
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic             take, pick;
  logic [WIDTH-1:0] opa, opb;
  logic [1:0]       opc;
  logic [WIDTH:0]   alu_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On a tie the requester that did not own the previous result wins.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          pick      = (req0 && req1) ? ~last : req1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = EXEC;
      EXEC: state_nxt = DONE;
      DONE: if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_full = '0;
    case (opc)
      2'b00:   alu_full = {1'b0, opa} + {1'b0, opb};
      2'b01:   alu_full = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
      2'b10:   alu_full = {1'b0, opa & opb};
      default: alu_full = {1'b0, opa | opb};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last         <= 1'b1;
      sel          <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      cout         <= 1'b0;
      result_id    <= 1'b0;
      opa          <= '0;
      opb          <= '0;
      opc          <= 2'b00;
    end else begin
      gnt0 <= take && !pick;
      gnt1 <= take && pick;
      busy <= (state_nxt != IDLE);
      if (take) sel <= pick;
      if (state == LOAD) begin
        opa <= sel ? a1 : a0;
        opb <= sel ? b1 : b0;
        opc <= sel ? op1 : op0;
      end
      if (state == EXEC) begin
        result       <= alu_full[WIDTH-1:0];
        cout         <= alu_full[WIDTH];
        result_id    <= sel;
        result_valid <= 1'b1;
      end
      if (state == DONE && ack) begin
        result_valid <= 1'b0;
        last         <= result_id;
      end
    end
  end

endmodule
